// File: rtl/frame_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_gen
// Purpose  : Frames an upstream pixel stream into ROW x COL with sof/eol/eof
//            markers, an optional inter-line blank and a one-deep output reg.
// Revision : 1.0 - initial release
// ============================================================================
module frame_stream_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW        = 480,
    parameter int COL        = 640,
    parameter int HBLANK     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_sof,
    output logic                  dout_eol,
    output logic                  dout_eof,
    output logic [9:0]            col_cnt,
    output logic [9:0]            row_cnt
);

    localparam int              HB_W      = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [HB_W-1:0] C_HB_LAST = HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [9:0]      C_COL_LAST = 10'(COL - 1);
    localparam logic [9:0]      C_ROW_LAST = 10'(ROW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t                r_state;
    logic [HB_W-1:0]       r_hb_cnt;
    logic [9:0]            r_col;
    logic [9:0]            r_row;
    logic [DATA_WIDTH-1:0] r_dout_data;
    logic                  r_dout_valid;
    logic                  r_sof;
    logic                  r_eol;
    logic                  r_eof;

    logic w_drain_ok;
    logic w_src_ready;
    logic w_accept;

    // Output register is free when empty or being emptied this cycle.
    assign w_drain_ok  = !r_dout_valid || dout_ready;
    assign w_src_ready = (r_state == ST_ACTIVE) && w_drain_ok;
    assign w_accept    = src_valid && w_src_ready;

    assign src_ready  = w_src_ready;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FLUSH) && w_drain_ok;
    assign dout_data  = r_dout_data;
    assign dout_valid = r_dout_valid;
    assign dout_sof   = r_sof;
    assign dout_eol   = r_eol;
    assign dout_eof   = r_eof;
    assign col_cnt    = r_col;
    assign row_cnt    = r_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hb_cnt     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_dout_data  <= '0;
            r_dout_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_eol        <= 1'b0;
            r_eof        <= 1'b0;
        end else begin
            // Flags come from the pre-increment position of the accepted beat.
            if (w_accept) begin
                r_dout_data  <= src_data;
                r_dout_valid <= 1'b1;
                r_sof        <= (r_col == '0) && (r_row == '0);
                r_eol        <= (r_col == C_COL_LAST);
                r_eof        <= (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
                r_sof        <= 1'b0;
                r_eol        <= 1'b0;
                r_eof        <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ACTIVE;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_accept) begin
                        if (r_col == C_COL_LAST) begin
                            r_col <= '0;
                            if (r_row == C_ROW_LAST) begin
                                r_row   <= '0;
                                r_state <= ST_FLUSH;
                            end else begin
                                r_row <= r_row + 10'd1;
                                if (HBLANK > 0) begin
                                    r_hb_cnt <= '0;
                                    r_state  <= ST_HBLANK;
                                end
                            end
                        end else begin
                            r_col <= r_col + 10'd1;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (r_hb_cnt == C_HB_LAST) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_hb_cnt <= r_hb_cnt + HB_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (w_drain_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
